// File: rtl/simmem_req_bank.sv
`default_nettype none
// ============================================================================
//  Module   : simmem_req_bank
//  Purpose  : Request-side delay bank of the simulated memory. Requests
//             (id, addr, delay) from the initiator are held in one of
//             Capacity slots until their delay expires. Matured requests are
//             then issued towards the memory model, oldest first. Requests
//             that share an ID always leave in arrival order.
//  Ports    : clk_i, rst_ni          - clock, asynchronous active-low reset
//             req_in_*               - incoming request (valid/ready handshake)
//             req_out_*              - issued request (valid/ready handshake)
//             occupancy_o            - number of occupied slots
//  Revision : 1.0 - initial release
// ============================================================================
module simmem_req_bank #(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned Capacity     = 8,
    parameter int unsigned CounterWidth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [IdWidth-1:0]           req_in_id_i,
    input  logic [AddrWidth-1:0]         req_in_addr_i,
    input  logic [CounterWidth-1:0]      req_in_delay_i,
    input  logic                         req_in_valid_i,
    output logic                         req_in_ready_o,
    output logic [IdWidth-1:0]           req_out_id_o,
    output logic [AddrWidth-1:0]         req_out_addr_o,
    output logic                         req_out_valid_o,
    input  logic                         req_out_ready_i,
    output logic [$clog2(Capacity+1)-1:0] occupancy_o
);

    localparam int unsigned c_idx_w = $clog2(Capacity);
    localparam int unsigned c_occ_w = $clog2(Capacity+1);

    // Slot storage
    logic [Capacity-1:0]     r_valid;
    logic [IdWidth-1:0]      r_id    [Capacity];
    logic [AddrWidth-1:0]    r_addr  [Capacity];
    logic [CounterWidth-1:0] r_cnt   [Capacity];
    // r_older[i][j] = 1 : slot j was allocated before slot i
    logic [Capacity-1:0]     r_older [Capacity];

    // Output stability lock
    logic                    r_lock;
    logic [c_idx_w-1:0]      r_lock_idx;
    logic [c_occ_w-1:0]      r_occ;

    logic [Capacity-1:0][Capacity-1:0] w_same_id;
    logic [Capacity-1:0]     w_elig;
    logic [Capacity-1:0]     w_sel_vec;
    logic [c_idx_w-1:0]      w_alloc_idx;
    logic [c_idx_w-1:0]      w_oldest_idx;
    logic [c_idx_w-1:0]      w_sel_idx;
    logic                    w_in_hs;
    logic                    w_out_hs;

    // ------------------------------------------------------------------
    // Per-slot eligibility and oldest-eligible selection
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < Capacity; i++) begin : g_slot
            for (genvar j = 0; j < Capacity; j++) begin : g_cmp
                assign w_same_id[i][j] = (r_id[i] == r_id[j]);
            end
            // Blocked while any older live slot carries the same ID
            assign w_elig[i] = r_valid[i] && (r_cnt[i] == '0) &&
                               !(|(r_older[i] & r_valid & w_same_id[i]));
            // Oldest eligible: no eligible slot is older than this one
            assign w_sel_vec[i] = w_elig[i] && !(|(r_older[i] & w_elig));
        end
    endgenerate

    always_comb begin
        w_oldest_idx = '0;
        for (int i = 0; i < Capacity; i++) begin
            if (w_sel_vec[i]) begin
                w_oldest_idx = c_idx_w'(i);
            end
        end
    end

    // Lowest-index free slot; only slots free at the start of the cycle count
    always_comb begin
        w_alloc_idx = '0;
        for (int i = Capacity - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_idx = c_idx_w'(i);
            end
        end
    end

    assign w_sel_idx       = r_lock ? r_lock_idx : w_oldest_idx;
    assign req_in_ready_o  = ~(&r_valid);
    assign req_out_valid_o = r_lock | (|w_elig);
    assign req_out_id_o    = req_out_valid_o ? r_id[w_sel_idx]   : '0;
    assign req_out_addr_o  = req_out_valid_o ? r_addr[w_sel_idx] : '0;
    assign occupancy_o     = r_occ;

    assign w_in_hs  = req_in_valid_i && req_in_ready_o;
    assign w_out_hs = req_out_valid_o && req_out_ready_i;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid    <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_occ      <= '0;
            for (int i = 0; i < Capacity; i++) begin
                r_id[i]    <= '0;
                r_addr[i]  <= '0;
                r_cnt[i]   <= '0;
                r_older[i] <= '0;
            end
        end else begin
            // Countdown saturates at zero
            for (int i = 0; i < Capacity; i++) begin
                if (r_valid[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CounterWidth'(1);
                end
            end

            if (w_out_hs) begin
                r_valid[w_sel_idx] <= 1'b0;
            end

            // The allocated slot was free, so it never collides with the
            // issued slot or the countdown above.
            if (w_in_hs) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_id[w_alloc_idx]    <= req_in_id_i;
                r_addr[w_alloc_idx]  <= req_in_addr_i;
                r_cnt[w_alloc_idx]   <= req_in_delay_i;
                r_older[w_alloc_idx] <= r_valid;
                for (int j = 0; j < Capacity; j++) begin
                    r_older[j][w_alloc_idx] <= 1'b0;
                end
            end

            // Hold the presented slot while downstream stalls
            r_lock     <= req_out_valid_o && !req_out_ready_i;
            r_lock_idx <= w_sel_idx;

            case ({w_in_hs, w_out_hs})
                2'b10:   r_occ <= r_occ + c_occ_w'(1);
                2'b01:   r_occ <= r_occ - c_occ_w'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simmem_req_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simmem_req_bank
//  Purpose  : Self-checking bench for simmem_req_bank. A reference model
//             keeps pending requests in an arrival-ordered queue with the
//             absolute cycle at which each one matures.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simmem_req_bank;

    localparam int Capacity = 8;
    localparam int OccW     = $clog2(Capacity + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      in_id = '0;
    logic [31:0]     in_addr = '0;
    logic [7:0]      in_delay = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      out_id;
    logic [31:0]     out_addr;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OccW-1:0] occ;

    always #5 clk = ~clk;

    simmem_req_bank #(
        .IdWidth(4), .AddrWidth(32), .Capacity(Capacity), .CounterWidth(8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_in_id_i    (in_id),
        .req_in_addr_i  (in_addr),
        .req_in_delay_i (in_delay),
        .req_in_valid_i (in_valid),
        .req_in_ready_o (in_ready),
        .req_out_id_o   (out_id),
        .req_out_addr_o (out_addr),
        .req_out_valid_o(out_valid),
        .req_out_ready_i(out_ready),
        .occupancy_o    (occ)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        int          mature;
        int          seq;
    } req_t;

    req_t        q[$];
    int          cyc = 0;
    int          seq_ctr = 0;
    bit          lock_on = 0;
    int          lock_seq = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          obs_valid;
    logic [3:0]  issued_id[$];
    logic [31:0] issued_addr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Oldest-arrived matured request with no earlier pending same-ID request,
    // unless a stalled presentation is still being held.
    function automatic int model_sel();
        bit blocked;
        if (lock_on) begin
            foreach (q[k]) if (q[k].seq == lock_seq) return k;
        end
        foreach (q[k]) begin
            if (q[k].mature <= cyc) begin
                blocked = 1'b0;
                for (int m = 0; m < k; m++) if (q[m].id == q[k].id) blocked = 1'b1;
                if (!blocked) return k;
            end
        end
        return -1;
    endfunction

    // One clock cycle: drive, compare against the model, advance.
    task automatic step(input bit iv, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] d, input bit ordy);
        int          sel;
        bit          exp_rdy, exp_v, in_hs, out_hs;
        logic [3:0]  exp_id;
        logic [31:0] exp_addr;
        in_valid = iv; in_id = id; in_addr = addr; in_delay = d; out_ready = ordy;
        #1;
        sel      = model_sel();
        exp_rdy  = (q.size() < Capacity);
        exp_v    = (sel >= 0);
        exp_id   = '0;
        exp_addr = '0;
        if (exp_v) begin
            exp_id   = q[sel].id;
            exp_addr = q[sel].addr;
        end
        check("in_ready",  in_ready,  exp_rdy);
        check("out_valid", out_valid, exp_v);
        check("out_id",    out_id,    exp_id);
        check("out_addr",  out_addr,  exp_addr);
        check("occupancy", occ,       q.size());
        obs_valid = out_valid;
        if (out_valid && ordy) begin
            issued_id.push_back(out_id);
            issued_addr.push_back(out_addr);
        end
        in_hs  = iv && exp_rdy;
        out_hs = exp_v && ordy;
        if (exp_v && !ordy) begin
            lock_on  = 1'b1;
            lock_seq = q[sel].seq;
        end else begin
            lock_on = 1'b0;
        end
        @(posedge clk);
        #1;
        if (out_hs) q.delete(sel);
        if (in_hs) begin
            q.push_back('{id, addr, cyc + int'(d) + 1, seq_ctr});
            seq_ctr++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) step(1'b0, '0, '0, '0, 1'b1);
        check("drain_empty", q.size(), 0);
        idle(2);
        issued_id.delete();
        issued_addr.delete();
    endtask

    int first_v;

    initial begin
        // Reset values while reset is held
        #1;
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_id",    out_id,    4'h0);
        check("rst_out_addr",  out_addr,  32'h0);
        check("rst_occupancy", occ,       0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, delay 5: valid rises 6 cycles after acceptance
        step(1'b1, 4'd3, 32'h1000, 8'd5, 1'b1);
        first_v = -1;
        for (int r = 1; r <= 10; r++) begin
            step(1'b0, '0, '0, '0, 1'b1);
            if (obs_valid && first_v < 0) first_v = r;
        end
        check("single_latency", first_v, 6);
        check("single_id",   issued_id.size() == 1 ? issued_id[0] : 4'hF, 4'd3);
        drain();

        // Same ID: a zero-delay request waits behind an older slow one
        step(1'b1, 4'd2, 32'hA, 8'd10, 1'b1);
        step(1'b1, 4'd2, 32'hB, 8'd0,  1'b1);
        idle(16);
        check("sameid_count", issued_addr.size(), 2);
        if (issued_addr.size() == 2) begin
            check("sameid_first",  issued_addr[0], 32'hA);
            check("sameid_second", issued_addr[1], 32'hB);
        end
        drain();

        // Different IDs: short delay overtakes
        step(1'b1, 4'd1, 32'h11, 8'd8, 1'b1);
        step(1'b1, 4'd4, 32'h44, 8'd1, 1'b1);
        idle(14);
        check("diffid_count", issued_id.size(), 2);
        if (issued_id.size() == 2) begin
            check("diffid_first",  issued_id[0], 4'd4);
            check("diffid_second", issued_id[1], 4'd1);
        end
        drain();

        // Fill all slots with ready low, hold, then drain in arrival order
        for (int k = 0; k < Capacity; k++)
            step(1'b1, 4'(k), 32'(k * 256), 8'd0, 1'b0);
        check("full_ready", in_ready, 1'b0);
        check("full_occ",   occ, Capacity);
        for (int k = 0; k < 20; k++) step(1'b1, 4'hF, 32'hDEAD, 8'd0, 1'b0);
        for (int k = 0; k < Capacity + 2; k++) step(1'b0, '0, '0, '0, 1'b1);
        check("full_drain_count", issued_addr.size(), Capacity);
        for (int k = 0; k < Capacity && k < issued_addr.size(); k++)
            check("full_drain_order", issued_addr[k], 32'(k * 256));
        drain();

        // Lock: newer id 5 presented under stall while older id 6 matures
        step(1'b1, 4'd6, 32'h600, 8'd4, 1'b0);
        step(1'b1, 4'd5, 32'h500, 8'd0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, '0, '0, '0, 1'b0);
        check("lock_hold_id", out_id, 4'd5);
        step(1'b0, '0, '0, '0, 1'b1);
        check("lock_after_id", out_id, 4'd6);
        drain();

        // Asynchronous reset mid-countdown
        step(1'b1, 4'd7, 32'h70, 8'd1,  1'b0);
        step(1'b1, 4'd8, 32'h80, 8'd20, 1'b0);
        step(1'b1, 4'd9, 32'h90, 8'd20, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_occupancy", occ, 0);
        check("arst_in_ready",  in_ready, 1'b1);
        q.delete();
        lock_on = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(30);

        // Randomised traffic with few IDs to force same-ID ordering
        for (int k = 0; k < 500; k++)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
                 8'($urandom_range(0, 12)), ($urandom_range(0, 3) != 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
